pim_conv_sched: RTL and testbench

//  Sequencer for the PIM conv crossbar datapath. Accepts input feature vectors over a valid/ready stream
//  and sweeps each vector across all crossbar columns through the conv Address/en interface.

---
 rtl/pim_sched_pkg.sv | 24 ++
 rtl/pim_conv_sched_if.sv | 33 +++
 rtl/pim_sched_acc_bank.sv | 35 +++
 rtl/pim_conv_sched.sv | 141 ++++++++++++++
 tb/tb_pim_conv_sched.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/pim_sched_pkg.sv
// Shared types and arithmetic helpers for the PIM conv crossbar scheduler.
package pim_sched_pkg;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StOut} state_e;

  // Sign-extend the low w bits of v to 32 bits.
  function automatic logic signed [31:0] sext(input logic [31:0] v, input int unsigned w);
    logic [31:0] sh;
    sh = v << (32 - w);
    return $signed(sh) >>> (32 - w);
  endfunction

  // Clamp v into the signed range of a w-bit two's complement value.
  function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int unsigned w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/pim_conv_sched_if.sv
// Feature-in stream, crossbar access bus and column-sum out stream of the conv scheduler.
interface pim_conv_sched_if #(
  parameter int unsigned INPUT_SIZE = 32,
  parameter int unsigned DEPTH      = 5,
  parameter int unsigned ADC_P      = 8,
  parameter int unsigned ACC_W      = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [INPUT_SIZE-1:0] in_data;
  logic                  in_last;
  logic                  pim_en;
  logic [DEPTH-1:0]      pim_addr;
  logic [INPUT_SIZE-1:0] pim_feature;
  logic [ADC_P-1:0]      pim_result;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_W-1:0]      out_data;
  logic [DEPTH-1:0]      out_col;
  logic                  out_last;

  // Scheduler side.
  modport slave (
    input  in_valid, in_data, in_last, pim_result, out_ready,
    output in_ready, pim_en, pim_addr, pim_feature, out_valid, out_data, out_col, out_last
  );

  // Environment side: feature fetch, crossbar and writeback.
  modport master (
    output in_valid, in_data, in_last, pim_result, out_ready,
    input  in_ready, pim_en, pim_addr, pim_feature, out_valid, out_data, out_col, out_last
  );
endinterface

// File: rtl/pim_sched_acc_bank.sv
// Per-column accumulator register file: load or saturating add on write, one read port.
module pim_sched_acc_bank
  import pim_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 5,
  parameter int unsigned ADC_P = 8,
  parameter int unsigned ACC_W = 16
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [DEPTH-1:0] wr_col_i,
  input  logic             wr_load_i,
  input  logic [ADC_P-1:0] wr_res_i,
  input  logic [DEPTH-1:0] rd_col_i,
  output logic [ACC_W-1:0] rd_data_o
);
  localparam int unsigned COLS = 1 << DEPTH;

  logic [ACC_W-1:0] mem_q [COLS];
  logic [ACC_W-1:0] wr_data;

  always_comb begin
    wr_data = wr_load_i ? ACC_W'(sext(32'(wr_res_i), ADC_P))
                        : ACC_W'(sat(32'($signed(mem_q[wr_col_i])) +
                                     sext(32'(wr_res_i), ADC_P), ACC_W));
  end

  // No reset: the first pass of every frame overwrites each column.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_col_i] <= wr_data;
  end

  assign rd_data_o = mem_q[rd_col_i];

endmodule

// File: rtl/pim_conv_sched.sv
// Sweeps each feature vector over all crossbar columns and streams per-frame column sums.
// Build option: define PIM_SCHED_RELU_EN to clamp negative sums to zero on the output path.
module pim_conv_sched
  import pim_sched_pkg::*;
#(
  parameter int unsigned INPUT_SIZE = 32,
  parameter int unsigned DEPTH      = 5,
  parameter int unsigned ADC_P      = 8,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned ACC_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  pim_conv_sched_if.slave  bus,
  output logic             busy
);
  localparam int unsigned CntW = $clog2(RD_LAT + 1);

  state_e                state_q, state_d;
  logic [DEPTH-1:0]      addr_q, addr_d;
  logic [DEPTH-1:0]      out_col_q, out_col_d;
  logic [INPUT_SIZE-1:0] feature_q, feature_d;
  logic                  frame_last_q, frame_last_d;
  logic                  first_pass_q, first_pass_d;
  logic [CntW-1:0]       drain_q, drain_d;
  logic                  issue;
  logic                  pipe_vld_q [RD_LAT];
  logic [DEPTH-1:0]      pipe_col_q [RD_LAT];
  logic [ACC_W-1:0]      acc_rd;

  assign issue = (state_q == StIssue);

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    out_col_d     = out_col_q;
    feature_d     = feature_q;
    frame_last_d  = frame_last_q;
    first_pass_d  = first_pass_q;
    drain_d       = drain_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    unique case (state_q)
      StIdle: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          feature_d    = bus.in_data;
          frame_last_d = bus.in_last;
          addr_d       = '0;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        addr_d = addr_q + 1'b1;
        if (&addr_q) begin
          drain_d = '0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == CntW'(RD_LAT - 1)) begin
          first_pass_d = 1'b0;
          state_d      = frame_last_q ? StOut : StIdle;
        end
      end
      StOut: begin
        bus.out_valid = 1'b1;
        bus.out_last  = &out_col_q;
        if (bus.out_ready) begin
          out_col_d = out_col_q + 1'b1;
          if (&out_col_q) begin
            out_col_d    = '0;
            first_pass_d = 1'b1;
            state_d      = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      out_col_q    <= '0;
      feature_q    <= '0;
      frame_last_q <= 1'b0;
      first_pass_q <= 1'b1;
      drain_q      <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_vld_q[i] <= 1'b0;
        pipe_col_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      out_col_q    <= out_col_d;
      feature_q    <= feature_d;
      frame_last_q <= frame_last_d;
      first_pass_q <= first_pass_d;
      drain_q      <= drain_d;
      // Tracks which column each in-flight result belongs to.
      pipe_vld_q[0] <= issue;
      pipe_col_q[0] <= addr_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_col_q[i] <= pipe_col_q[i-1];
      end
    end
  end

  pim_sched_acc_bank #(
    .DEPTH (DEPTH),
    .ADC_P (ADC_P),
    .ACC_W (ACC_W)
  ) u_acc_bank (
    .clk_i     (clk),
    .wr_en_i   (pipe_vld_q[RD_LAT-1]),
    .wr_col_i  (pipe_col_q[RD_LAT-1]),
    .wr_load_i (first_pass_q),
    .wr_res_i  (bus.pim_result),
    .rd_col_i  (out_col_q),
    .rd_data_o (acc_rd)
  );

  assign bus.pim_en      = issue;
  assign bus.pim_addr    = addr_q;
  assign bus.pim_feature = feature_q;
  assign bus.out_col     = out_col_q;
  assign busy            = (state_q != StIdle);

`ifdef PIM_SCHED_RELU_EN
  assign bus.out_data = acc_rd[ACC_W-1] ? '0 : acc_rd;
`else
  assign bus.out_data = acc_rd;
`endif

endmodule

// File: tb/tb_pim_conv_sched.sv
// Directed bench for pim_conv_sched with a one-cycle-latency crossbar model (ACC_W=10).
module tb_pim_conv_sched;
  localparam int unsigned INPUT_SIZE = 32;
  localparam int unsigned DEPTH      = 5;
  localparam int unsigned ADC_P      = 8;
  localparam int unsigned RD_LAT     = 1;
  localparam int unsigned ACC_W      = 10;
  localparam int unsigned COLS       = 1 << DEPTH;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pim_conv_sched_if #(
    .INPUT_SIZE (INPUT_SIZE),
    .DEPTH      (DEPTH),
    .ADC_P      (ADC_P),
    .ACC_W      (ACC_W)
  ) bus ();

  pim_conv_sched #(
    .INPUT_SIZE (INPUT_SIZE),
    .DEPTH      (DEPTH),
    .ADC_P      (ADC_P),
    .RD_LAT     (RD_LAT),
    .ACC_W      (ACC_W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  // Crossbar model: result for the column issued one cycle earlier, junk otherwise.
  logic                    res_vld;
  logic [DEPTH-1:0]        res_col;
  bit                      mode_col;
  logic signed [ADC_P-1:0] res_val;
  always @(posedge clk) begin
    res_vld <= bus.pim_en;
    res_col <= bus.pim_addr;
  end
  assign bus.pim_result = (res_vld !== 1'b1) ? 8'h5A :
                          (mode_col ? ADC_P'(res_col) : res_val);

  typedef struct {
    int     passes;
    bit     col_mode;
    int     val;
    bit [3:0] rdy_pat;
    int     exp_sum;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic int relu_f(input int v);
`ifdef PIM_SCHED_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic check_reset_state();
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_pim_en", bus.pim_en, 0);
    check("rst_pim_addr", bus.pim_addr, 0);
    check("rst_pim_feature", bus.pim_feature, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_col", bus.out_col, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_busy", busy, 0);
  endtask

  // Called at a negedge; returns at the negedge right after the sweep has drained.
  task automatic run_pass(input logic [31:0] data, input bit last);
    int guard = 0;
    int bad   = 0;
    while (bus.in_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_wait", bus.in_ready, 1);
    bus.in_data  = data;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    @(negedge clk);
    // Offer a different vector during the sweep; it must be ignored.
    bus.in_data = ~data;
    bus.in_last = ~last;
    for (int k = 1; k <= COLS + RD_LAT; k++) begin
      if (k > 1) @(negedge clk);
      if (k == COLS + RD_LAT) bus.in_valid = 1'b0;
      if (bus.in_ready !== 1'b0 || busy !== 1'b1) bad++;
      if (k <= COLS) begin
        if (bus.pim_en !== 1'b1 || bus.pim_addr !== DEPTH'(k - 1) || bus.pim_feature !== data)
          bad++;
      end else if (bus.pim_en !== 1'b0) begin
        bad++;
      end
    end
    check("sweep_seq_errors", bad, 0);
    @(negedge clk);
    check("post_sweep_valid_ready", {bus.out_valid, bus.in_ready}, last ? 2 : 1);
  endtask

  task automatic collect(input bit col_mode, input int exp_sum, input bit [3:0] pat);
    int beat = 0;
    int cyc  = 0;
    bit stalled = 1'b0;
    bit rdy;
    logic [ACC_W-1:0] hold_d;
    logic [DEPTH-1:0] hold_c;
    int exp;
    while (beat < COLS && cyc < 1000) begin
      if (stalled) begin
        check("stall_hold", {bus.out_col, bus.out_data}, {hold_c, hold_d});
        stalled = 1'b0;
      end
      rdy = pat[cyc % 4];
      bus.out_ready = rdy;
      if (bus.out_valid === 1'b1) begin
        if (rdy) begin
          exp = relu_f(col_mode ? beat : exp_sum);
          check("out_data", $signed(bus.out_data), exp);
          check("out_col", bus.out_col, beat);
          check("out_last", bus.out_last, (beat == COLS - 1) ? 1 : 0);
          beat++;
        end else begin
          stalled = 1'b1;
          hold_d  = bus.out_data;
          hold_c  = bus.out_col;
        end
      end
      cyc++;
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    check("beat_count", beat, COLS);
    check("out_done_state", {bus.out_valid, bus.in_ready, busy}, 3'b010);
  endtask

  task automatic run_frame(input vec_t v);
    mode_col = v.col_mode;
    res_val  = ADC_P'(v.val);
    for (int p = 0; p < v.passes; p++) run_pass($urandom, (p == v.passes - 1));
    collect(v.col_mode, v.exp_sum, v.rdy_pat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    //          passes col val  ready    sum
    vecs[0] = '{1,  1'b1,    0, 4'b1111,    0};
    vecs[1] = '{3,  1'b0,   -2, 4'b1111,   -6};
    vecs[2] = '{10, 1'b0,  127, 4'b1111,  511};
    vecs[3] = '{10, 1'b0, -128, 4'b1111, -512};
    vecs[4] = '{1,  1'b0,   -3, 4'b1111,   -3};
    vecs[5] = '{4,  1'b0,    3, 4'b1001,   12};
    vecs[6] = '{2,  1'b0,  100, 4'b1001,  200};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    mode_col      = 1'b0;
    res_val       = '0;
    rst           = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run_frame(vecs[i]);

    // Reset in the middle of the second pass, then a fresh single-pass frame.
    mode_col = 1'b0;
    res_val  = 8'sd9;
    run_pass(32'h1234_5678, 1'b0);
    bus.in_data  = 32'hCAFE_0001;
    bus.in_last  = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    guard = 0;
    while (bus.pim_addr !== DEPTH'(7) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("reach_col7", bus.pim_addr, 7);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    @(negedge clk);
    run_frame('{1, 1'b0, 5, 4'b1111, 5});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
